axi_lite_req_arbiter: RTL and testbench
=======================================

Name: axi_lite_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AXI-lite master user port (rd_addr/rd_en/rd_be/rd_data/rd_data_valid and wr_addr/wr_be/wr_data/wr_en/wr_busy) between NUM_REQ requesters, e.g. PCIe BAR target, config engine and debug port.
- Serialises all traffic: at most one read or write outstanding.
- Generates the single-cycle rd_en/wr_en strobes the master edge-detects.
- Maps completions back to the owning requester and times out hung transactions.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 1024, max cycles from strobe to completion; 0 disables the timeout.
ERR_DATA, 32'hDEADDEAD, rsp_rdata returned on read timeout.

Ports:
ACLK  in  1  clock
ARESET  in  1  reset; asynchronous, active-high (already decided)
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept, combinational, same cycle as grant
req_wr  in  NUM_REQ  1 = write, 0 = read
req_addr  in  32*NUM_REQ  word address incl. BAR index in [31:30], slice i = [32i+31:32i]
req_be  in  4*NUM_REQ  byte enables
req_wdata  in  32*NUM_REQ  write data
rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse
rsp_rdata  out  32  read data (shared, qualified by rsp_valid)
rsp_err  out  1  timeout flag (qualified by rsp_valid)
rd_addr, rd_be, rd_en  out  32,4,1  to master read side
rd_data, rd_data_valid  in  32,1  from master
wr_addr, wr_be, wr_data, wr_en  out  32,4,32,1  to master write side
wr_busy  in  1  from master; low = write response present

Behaviour:
- Reset (async assert, synchronous-to-ACLK release): state IDLE; all registered outputs 0; req_ready forced 0 while ARESET is high; rr pointer = 0; timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first requester with req_valid=1, searching from (last_grant+1) mod NUM_REQ.
  - Assert req_ready[g] in the same cycle.
  - Latch wr/addr/be/wdata and g.
  - Load rd_* or wr_* outputs and set rd_en or wr_en = 1 for the next cycle.
  - Go to ISSUE. No valid request: stay.
- ISSUE:
  - Exactly one cycle.
  - The selected en is high; addr/be/data are stable in this cycle and held afterwards.
  - Clear en; clear timeout counter; go to WAIT.
  - en is always low for at least one cycle between strobes, as required by the master's edge detect.
- WAIT:
  - Read completes on rd_data_valid=1: latch rd_data, rsp_err=0.
  - Write completes on wr_busy=0: rsp_err=0.
  - Completion of the other type is ignored.
  - Counter increments each cycle. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without completion: rsp_err=1, rsp_rdata=ERR_DATA (reads; writes return 0).
  - Either case goes to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle; set last_grant=g.
  - Go to IDLE; the next grant is possible in the following cycle.
- Latency:
  - Accept at cycle 0; strobe at cycle 1.
  - Completion seen at cycle k gives rsp_valid at k+1.
  - Minimum request-to-request spacing is 4 cycles.
- Late completion after a timeout, arriving while in IDLE/ISSUE: ignored, never routed to any requester. rd_data_valid/wr_busy=0 in ISSUE is not a completion.
- Simultaneous requests: strict round-robin; a continuously requesting requester cannot win twice while another is pending.
- req_valid dropped before grant: no effect. Requesters hold the payload until req_ready.
- ARESET mid-transaction: abort immediately, no rsp_valid. The master's own reset is the integrator's responsibility.
- Timeout counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- Package axi_lite_arb_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), ERR_DATA default, MAX_REQ=4, slice-index helper function.
- Sub-module rr_priority_pick: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, index, any.
  - Unit-tested separately.

Test Plan:
- Req0 read addr 32'h4000_0010, master returns rd_data_valid with 32'h1234_5678 at cycle 5 -> rd_en high cycle 1 only, rd_addr=32'h4000_0010; rsp_valid[0] cycle 6, rsp_rdata=32'h1234_5678, rsp_err=0.
- Req1 write addr 32'h8000_0004, be 4'b0011, data 32'hCAFE_F00D; wr_busy low at cycle 4 -> wr_en high cycle 1, wr_be=4'b0011, wr_data=32'hCAFE_F00D; rsp_valid[1] cycle 5.
- Req0 and req1 both valid continuously for 4 transactions, fixed 3-cycle completion -> grants 0,1,0,1; no rd_en/wr_en ever high for two consecutive cycles.
- TIMEOUT_CYCLES=16, read never completes -> rsp_valid at strobe+17, rsp_err=1, rsp_rdata=32'hDEADDEAD; later rd_data_valid in IDLE produces no rsp_valid.
- ARESET asserted during WAIT of a write -> all outputs 0 asynchronously, no rsp_valid. After release, a new req1 read is granted and completes normally.
- TIMEOUT_CYCLES=0, completion at 5000 cycles -> no timeout; rsp_valid and correct data.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI-lite request arbiter.
// State encoding, requester index type and payload slice helper.
package axi_lite_arb_pkg;

  localparam int unsigned MAX_REQ = 4;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADDEAD;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Low bit of slice idx in a flat vector of width-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/axi_lite_req_arbiter_if.sv
// Requester-side and master-user-port signals of the arbiter.
// master = arbiter view, slave = requesters plus AXI-lite master user port.
interface axi_lite_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_wr;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [4*NUM_REQ-1:0]  req_be;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [31:0]           rd_addr;
  logic [3:0]            rd_be;
  logic                  rd_en;
  logic [31:0]           rd_data;
  logic                  rd_data_valid;
  logic [31:0]           wr_addr;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic                  wr_en;
  logic                  wr_busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_be, req_wdata, rd_data, rd_data_valid, wr_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rd_addr, rd_be, rd_en,
           wr_addr, wr_be, wr_data, wr_en
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_be, req_wdata, rd_data, rd_data_valid, wr_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rd_addr, rd_be, rd_en,
           wr_addr, wr_be, wr_data, wr_en
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester after last_grant_i wins.
module rr_priority_pick
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_t           index_o,
  output logic               any_o
);

  int unsigned        cand;
  logic [NUM_REQ-1:0] cand_mask;

  always_comb begin
    grant_o   = '0;
    index_o   = '0;
    any_o     = 1'b0;
    cand      = 0;
    cand_mask = '0;
    // Offset NUM_REQ wraps back to last_grant_i itself, so it is tried last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand      = (32'(last_grant_i) + off) % NUM_REQ;
      cand_mask = NUM_REQ'(1) << cand;
      if (!any_o && |(req_i & cand_mask)) begin
        any_o   = 1'b1;
        grant_o = cand_mask;
        index_o = req_idx_t'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master user port between NUM_REQ requesters,
// one transaction outstanding, with single-cycle strobes and completion timeout.
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input logic                   ACLK,
  input logic                   ARESET,
  axi_lite_req_arbiter_if.master bus
);

  localparam int unsigned CntW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  arb_state_e state_q, state_d;
  req_idx_t   gnt_q, gnt_d;
  req_idx_t   last_q, last_d;
  logic       wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] rd_addr_q, rd_addr_d;
  logic [3:0]  rd_be_q, rd_be_d;
  logic        rd_en_q, rd_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  req_idx_t           pick_idx;
  logic               pick_any;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;
  logic               sel_wr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i        (bus.req_valid),
    .last_grant_i (last_q),
    .grant_o      (pick_gnt),
    .index_o      (pick_idx),
    .any_o        (pick_any)
  );

  assign sel_addr  = 32'(bus.req_addr >> slice_lo(32'(pick_idx), 32));
  assign sel_wdata = 32'(bus.req_wdata >> slice_lo(32'(pick_idx), 32));
  assign sel_be    = 4'(bus.req_be >> slice_lo(32'(pick_idx), 4));
  assign sel_wr    = |(bus.req_wr & pick_gnt);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_be_d     = rd_be_q;
    rd_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_be_d     = wr_be_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus.req_ready = '0;

    case (state_q)
      StIdle: begin
        if (pick_any && !ARESET) begin
          bus.req_ready = pick_gnt;
          gnt_d         = pick_idx;
          wr_d          = sel_wr;
          if (sel_wr) begin
            wr_addr_d = sel_addr;
            wr_be_d   = sel_be;
            wr_data_d = sel_wdata;
            wr_en_d   = 1'b1;
          end else begin
            rd_addr_d = sel_addr;
            rd_be_d   = sel_be;
            rd_en_d   = 1'b1;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (!wr_q && bus.rd_data_valid) begin
          rsp_rdata_d = bus.rd_data;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (wr_q && !bus.wr_busy) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntW'(TimeoutLast)) begin
          rsp_rdata_d = wr_q ? 32'h0 : ERR_DATA;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = (state_q == StResp) && (gnt_q == req_idx_t'(i));
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      last_q      <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rd_be_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_be_q     <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_be_q     <= rd_be_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_be_q     <= wr_be_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_be     = rd_be_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_be     = wr_be_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: directed and random transactions against a
// transaction-level round-robin model, plus a no-timeout instance.
module tb_axi_lite_req_arbiter;

  localparam int NREQ = 2;
  localparam int TO_A = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_req_arbiter_if #(.NUM_REQ(NREQ)) bus_a ();
  axi_lite_req_arbiter_if #(.NUM_REQ(NREQ)) bus_b ();

  axi_lite_req_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TO_A),
    .ERR_DATA       (32'hDEADDEAD)
  ) u_dut_a (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus_a.master)
  );

  axi_lite_req_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (0),
    .ERR_DATA       (32'hDEADDEAD)
  ) u_dut_b (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus_b.master)
  );

  int checks = 0;
  int errors = 0;
  int model_last = 0;

  logic        p_wr    [NREQ];
  logic [31:0] p_addr  [NREQ];
  logic [3:0]  p_be    [NREQ];
  logic [31:0] p_wdata [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Winner = first valid requester after the previous winner, wrapping.
  function automatic int rr_model(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (model_last + k) % NREQ;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  task automatic drive_req(input logic [NREQ-1:0] m);
    bus_a.req_valid = m;
    bus_a.req_wr    = {p_wr[1], p_wr[0]};
    bus_a.req_addr  = {p_addr[1], p_addr[0]};
    bus_a.req_be    = {p_be[1], p_be[0]};
    bus_a.req_wdata = {p_wdata[1], p_wdata[0]};
  endtask

  // One transaction on instance A. Completion at strobe+lat; lat==0 never completes.
  task automatic do_txn(input logic [NREQ-1:0] vmask, input int lat, input logic [31:0] rdv,
                        output int g);
    int eff;
    bit to;
    logic [31:0] exp_rd;
    g   = rr_model(vmask);
    to  = (lat == 0);
    eff = to ? TO_A : lat;
    next_cycle();
    bus_a.rd_data_valid = 1'b0;
    bus_a.wr_busy       = 1'b1;
    drive_req(vmask);
    #1;
    chk("ready_grant", 32'(bus_a.req_ready), 32'(1 << g));
    chk("en_before", {30'h0, bus_a.rd_en, bus_a.wr_en}, 32'h0);
    next_cycle();
    drive_req(vmask & ~(NREQ'(1) << g));
    // A completion-looking input during the strobe cycle must be ignored.
    if (p_wr[g]) bus_a.wr_busy = 1'b0;
    else begin
      bus_a.rd_data_valid = 1'b1;
      bus_a.rd_data       = 32'hBAD0_0001;
    end
    #1;
    chk("ready_issue", 32'(bus_a.req_ready), 32'h0);
    if (p_wr[g]) begin
      chk("wr_en", 32'(bus_a.wr_en), 32'h1);
      chk("rd_en_off", 32'(bus_a.rd_en), 32'h0);
      chk("wr_addr", bus_a.wr_addr, p_addr[g]);
      chk("wr_be", 32'(bus_a.wr_be), 32'(p_be[g]));
      chk("wr_data", bus_a.wr_data, p_wdata[g]);
    end else begin
      chk("rd_en", 32'(bus_a.rd_en), 32'h1);
      chk("wr_en_off", 32'(bus_a.wr_en), 32'h0);
      chk("rd_addr", bus_a.rd_addr, p_addr[g]);
      chk("rd_be", 32'(bus_a.rd_be), 32'(p_be[g]));
    end
    for (int c = 2; c <= eff + 1; c++) begin
      next_cycle();
      bus_a.rd_data_valid = 1'b0;
      bus_a.wr_busy       = 1'b1;
      if (p_wr[g]) begin
        bus_a.rd_data_valid = 1'b1;
        bus_a.rd_data       = $urandom;
      end else begin
        bus_a.wr_busy = 1'b0;
      end
      if (c == eff + 1 && !to) begin
        if (p_wr[g]) bus_a.wr_busy = 1'b0;
        else begin
          bus_a.rd_data_valid = 1'b1;
          bus_a.rd_data       = rdv;
        end
      end
      #1;
      chk("en_wait", {30'h0, bus_a.rd_en, bus_a.wr_en}, 32'h0);
      chk("rsp_early", 32'(bus_a.rsp_valid), 32'h0);
    end
    next_cycle();
    bus_a.rd_data_valid = 1'b0;
    bus_a.wr_busy       = 1'b1;
    #1;
    exp_rd = p_wr[g] ? 32'h0 : (to ? 32'hDEADDEAD : rdv);
    chk("rsp_valid", 32'(bus_a.rsp_valid), 32'(1 << g));
    chk("rsp_rdata", bus_a.rsp_rdata, exp_rd);
    chk("rsp_err", 32'(bus_a.rsp_err), 32'(to));
    chk("ready_resp", 32'(bus_a.req_ready), 32'h0);
    model_last = g;
  endtask

  initial begin
    int g;
    int early;
    logic [NREQ-1:0] pend;
    for (int i = 0; i < NREQ; i++) begin
      p_wr[i] = 1'b0; p_addr[i] = '0; p_be[i] = '0; p_wdata[i] = '0;
    end
    drive_req('0);
    bus_a.rd_data = '0; bus_a.rd_data_valid = 1'b0; bus_a.wr_busy = 1'b1;
    bus_b.req_valid = '0; bus_b.req_wr = '0; bus_b.req_addr = '0; bus_b.req_be = '0;
    bus_b.req_wdata = '0; bus_b.rd_data = '0; bus_b.rd_data_valid = 1'b0; bus_b.wr_busy = 1'b1;

    // Reset state, with requests present.
    next_cycle();
    next_cycle();
    bus_a.req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(bus_a.req_ready), 32'h0);
    chk("rst_en", {30'h0, bus_a.rd_en, bus_a.wr_en}, 32'h0);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'h0);
    chk("rst_rdata", bus_a.rsp_rdata, 32'h0);
    bus_a.req_valid = '0;
    next_cycle();
    rst = 1'b0;

    // Read on requester 0, completion 4 cycles after strobe.
    p_wr[0] = 1'b0; p_addr[0] = 32'h4000_0010; p_be[0] = 4'hF;
    do_txn(2'b01, 4, 32'h1234_5678, g);
    // Write on requester 1, completion 3 cycles after strobe.
    p_wr[1] = 1'b1; p_addr[1] = 32'h8000_0004; p_be[1] = 4'b0011; p_wdata[1] = 32'hCAFE_F00D;
    do_txn(2'b10, 3, 32'h0, g);
    // Both requesting continuously.
    p_addr[0] = 32'h4000_0020;
    for (int t = 0; t < 4; t++) do_txn(2'b11, 3, 32'hA000_0000 + 32'(t), g);

    // Read timeout, then late completions in IDLE.
    do_txn(2'b01, 0, 32'h0, g);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus_a.rd_data_valid = 1'b1;
      bus_a.rd_data       = 32'h7777_0000;
      bus_a.wr_busy       = 1'b0;
      #1;
      chk("late_cpl", 32'(bus_a.rsp_valid), 32'h0);
    end
    // Write timeout returns zero data.
    do_txn(2'b10, 0, 32'h0, g);

    // Reset during WAIT of a write.
    next_cycle();
    drive_req(2'b10);
    #1;
    chk("rstw_ready", 32'(bus_a.req_ready), 32'h2);
    next_cycle();
    drive_req(2'b01);
    #1;
    chk("rstw_wr_en", 32'(bus_a.wr_en), 32'h1);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(bus_a.req_ready), 32'h0);
    chk("arst_en", {30'h0, bus_a.rd_en, bus_a.wr_en}, 32'h0);
    chk("arst_wr_addr", bus_a.wr_addr, 32'h0);
    chk("arst_wr_data", bus_a.wr_data, 32'h0);
    chk("arst_wr_be", 32'(bus_a.wr_be), 32'h0);
    chk("arst_rd_addr", bus_a.rd_addr, 32'h0);
    chk("arst_rsp_valid", 32'(bus_a.rsp_valid), 32'h0);
    chk("arst_rdata", bus_a.rsp_rdata, 32'h0);
    chk("arst_err", 32'(bus_a.rsp_err), 32'h0);
    bus_a.wr_busy = 1'b0;
    drive_req('0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    model_last = 0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      chk("abort_no_rsp", 32'(bus_a.rsp_valid), 32'h0);
    end
    p_wr[1] = 1'b0; p_addr[1] = 32'h0000_0100; p_be[1] = 4'hF;
    do_txn(2'b10, 2, 32'h600D_F00D, g);

    // Random traffic.
    pend = '0;
    for (int t = 0; t < 24; t++) begin
      logic [NREQ-1:0] arr;
      arr = NREQ'($urandom_range(0, 3)) & ~pend;
      if ((pend | arr) == '0) arr = NREQ'(1) << $urandom_range(0, NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (arr[i]) begin
          p_wr[i] = 1'($urandom_range(0, 1)); p_addr[i] = $urandom;
          p_be[i] = 4'($urandom_range(1, 15)); p_wdata[i] = $urandom;
        end
      end
      pend = pend | arr;
      do_txn(pend, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10), $urandom, g);
      pend = pend & ~(NREQ'(1) << g);
    end

    // Instance B: timeout disabled, completion after 5000 cycles.
    next_cycle();
    bus_b.req_valid = 2'b01;
    bus_b.req_wr    = 2'b00;
    bus_b.req_addr  = {32'h0, 32'h0000_0ABC};
    bus_b.req_be    = 8'h0F;
    #1;
    chk("b_ready", 32'(bus_b.req_ready), 32'h1);
    next_cycle();
    bus_b.req_valid = '0;
    #1;
    chk("b_rd_en", 32'(bus_b.rd_en), 32'h1);
    chk("b_rd_addr", bus_b.rd_addr, 32'h0000_0ABC);
    early = 0;
    for (int c = 2; c < 5000; c++) begin
      next_cycle();
      #1;
      if (bus_b.rsp_valid != '0) early++;
    end
    chk("b_no_timeout", 32'(early), 32'h0);
    next_cycle();
    bus_b.rd_data_valid = 1'b1;
    bus_b.rd_data       = 32'h5A5A_1234;
    next_cycle();
    bus_b.rd_data_valid = 1'b0;
    #1;
    chk("b_rsp_valid", 32'(bus_b.rsp_valid), 32'h1);
    chk("b_rsp_rdata", bus_b.rsp_rdata, 32'h5A5A_1234);
    chk("b_rsp_err", 32'(bus_b.rsp_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
